// File: rtl/scalar_branch_commit_pkg.sv
// rtl/scalar_branch_commit_pkg.sv - shared encodings for the scalar branch/commit stage
package scalar_branch_commit_pkg;

    localparam logic [1:0] SIGN_POS  = 2'b00;
    localparam logic [1:0] SIGN_ZERO = 2'b01;
    localparam logic [1:0] SIGN_NEG  = 2'b10;

    localparam logic [1:0] OPK_WB     = 2'd0;
    localparam logic [1:0] OPK_BRANCH = 2'd1;
    localparam logic [1:0] OPK_JAL    = 2'd2;
    localparam logic [1:0] OPK_JALR   = 2'd3;

    localparam logic [2:0] BRF_EQ = 3'b000;
    localparam logic [2:0] BRF_NE = 3'b001;
    localparam logic [2:0] BRF_LT = 3'b100;
    localparam logic [2:0] BRF_GE = 3'b101;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

endpackage

// File: rtl/scalar_branch_commit_branch_cond_eval.sv
// rtl/scalar_branch_commit_branch_cond_eval.sv - combinational branch taken/error decision
module branch_cond_eval
    import scalar_branch_commit_pkg::*;
(
    input  logic [2:0] br_funct,
    input  logic [1:0] sign_bits,
    input  logic       alu_msb,
    output logic       taken,
    output logic       err
);

    // alu_result holds rs1-rs2, so LT/GE only need its sign bit
    always_comb begin
        taken = 1'b0;
        err   = 1'b0;
        case (br_funct)
            BRF_EQ:  taken = (sign_bits == SIGN_ZERO);
            BRF_NE:  taken = (sign_bits != SIGN_ZERO);
            BRF_LT:  taken = alu_msb;
            BRF_GE:  taken = !alu_msb;
            default: err   = 1'b1;
        endcase
    end

endmodule

// File: rtl/scalar_branch_commit.sv
// rtl/scalar_branch_commit.sv - branch resolve, writeback register and wrong-path squash
// Optional branch statistics counters enabled by defining BRANCH_STATS_EN.
module scalar_branch_commit
    import scalar_branch_commit_pkg::*;
#(
    parameter int LEN         = 32,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     op_kind,
    input  logic [2:0]     br_funct,
    input  logic [LEN-1:0] alu_result,
    input  logic [1:0]     sign_bits,
    input  logic [LEN-1:0] pc,
    input  logic [LEN-1:0] imm,
    input  logic [4:0]     rd,
    output logic           wb_valid,
    input  logic           wb_ready,
    output logic [4:0]     wb_rd,
    output logic [LEN-1:0] wb_data,
    output logic           redirect_valid,
    output logic [LEN-1:0] redirect_pc,
    output logic           err_funct,
    output logic [31:0]    br_total,
    output logic [31:0]    br_taken
);

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_DEPTH);

    logic [0:0]     state_q, state_d;
    logic [2:0]     flush_cnt_q, flush_cnt_d;
    logic           wb_valid_q, wb_valid_d;
    logic [4:0]     wb_rd_q, wb_rd_d;
    logic [LEN-1:0] wb_data_q, wb_data_d;
    logic           redir_valid_q, redir_valid_d;
    logic [LEN-1:0] redir_pc_q, redir_pc_d;
    logic           err_q, err_d;

    logic           cond_taken, cond_err;
    logic           accept, run_acc, is_br, br_hit;
    logic [LEN-1:0] link_pc;

    branch_cond_eval u_cond (
        .br_funct  (br_funct),
        .sign_bits (sign_bits),
        .alu_msb   (alu_result[LEN-1]),
        .taken     (cond_taken),
        .err       (cond_err)
    );

    assign in_ready = (state_q == ST_FLUSH) || !wb_valid_q || wb_ready;
    assign accept   = in_valid && in_ready;
    assign run_acc  = accept && (state_q == ST_RUN);
    assign is_br    = (op_kind == OPK_BRANCH);
    assign br_hit   = run_acc && is_br && cond_taken;
    assign link_pc  = pc + LEN'(4);

    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        wb_valid_d    = wb_valid_q && !wb_ready;
        wb_rd_d       = wb_rd_q;
        wb_data_d     = wb_data_q;
        redir_valid_d = 1'b0;
        redir_pc_d    = redir_pc_q;
        err_d         = err_q;

        if (run_acc) begin
            if (!is_br && rd != 5'd0) begin
                wb_valid_d = 1'b1;
                wb_rd_d    = rd;
                wb_data_d  = (op_kind == OPK_WB) ? alu_result : link_pc;
            end
            if (is_br && cond_err) begin
                err_d = 1'b1;
            end
            if (br_hit || op_kind == OPK_JAL || op_kind == OPK_JALR) begin
                redir_valid_d = 1'b1;
                state_d       = ST_FLUSH;
                flush_cnt_d   = FLUSH_INIT;
                case (op_kind)
                    OPK_JAL:  redir_pc_d = alu_result;
                    OPK_JALR: redir_pc_d = alu_result & ~LEN'(1);
                    default:  redir_pc_d = pc + imm;
                endcase
            end
        end else if (accept) begin
            // wrong-path op: counted off and discarded
            flush_cnt_d = flush_cnt_q - 3'd1;
            if (flush_cnt_q == 3'd1) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RUN;
            flush_cnt_q   <= 3'd0;
            wb_valid_q    <= 1'b0;
            wb_rd_q       <= 5'd0;
            wb_data_q     <= '0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            wb_valid_q    <= wb_valid_d;
            wb_rd_q       <= wb_rd_d;
            wb_data_q     <= wb_data_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            err_q         <= err_d;
        end
    end

    assign wb_valid       = wb_valid_q;
    assign wb_rd          = wb_rd_q;
    assign wb_data        = wb_data_q;
    assign redirect_valid = redir_valid_q;
    assign redirect_pc    = redir_pc_q;
    assign err_funct      = err_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] br_total_q, br_taken_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_total_q <= 32'd0;
            br_taken_q <= 32'd0;
        end else begin
            if (run_acc && is_br) begin
                br_total_q <= br_total_q + 32'd1;
            end
            if (br_hit) begin
                br_taken_q <= br_taken_q + 32'd1;
            end
        end
    end

    assign br_total = br_total_q;
    assign br_taken = br_taken_q;
`else
    assign br_total = 32'd0;
    assign br_taken = 32'd0;
`endif

endmodule

// File: tb/tb_scalar_branch_commit.sv
// tb/tb_scalar_branch_commit.sv - directed self-checking bench for scalar_branch_commit
module tb_scalar_branch_commit;
    import scalar_branch_commit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  op_kind = OPK_WB;
    logic [2:0]  br_funct = 3'b000;
    logic [31:0] alu_result = '0;
    logic [1:0]  sign_bits = SIGN_POS;
    logic [31:0] pc = '0;
    logic [31:0] imm = '0;
    logic [4:0]  rd = '0;
    logic        wb_valid;
    logic        wb_ready = 1'b1;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        err_funct;
    logic [31:0] br_total, br_taken;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    scalar_branch_commit #(.LEN(32), .FLUSH_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_kind(op_kind), .br_funct(br_funct), .alu_result(alu_result),
        .sign_bits(sign_bits), .pc(pc), .imm(imm), .rd(rd),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .err_funct(err_funct), .br_total(br_total), .br_taken(br_taken)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [1:0] k, input logic [2:0] f, input logic [31:0] alu,
                          input logic [1:0] sb, input logic [31:0] p, input logic [31:0] im,
                          input logic [4:0] r);
        op_kind = k; br_funct = f; alu_result = alu; sign_bits = sb; pc = p; imm = im; rd = r;
    endtask

    // present one op for a single accepting edge, then sample just after it
    task automatic send(input logic [1:0] k, input logic [2:0] f, input logic [31:0] alu,
                        input logic [1:0] sb, input logic [31:0] p, input logic [31:0] im,
                        input logic [4:0] r);
        @(negedge clk);
        set_op(k, f, alu, sb, p, im, r);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    logic [31:0] exp_total, exp_taken;

    initial begin
`ifdef BRANCH_STATS_EN
        exp_total = 32'd3;
        exp_taken = 32'd1;
`else
        exp_total = 32'd0;
        exp_taken = 32'd0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_redirect_valid", redirect_valid, 0);
        check("rst_redirect_pc", redirect_pc, 0);
        check("rst_err", err_funct, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_br_total", br_total, 0);
        @(negedge clk);
        rst = 1'b0;

        send(OPK_WB, 3'b000, 32'h1234, SIGN_POS, 32'h0, 32'h0, 5'd5);
        check("wb_valid", wb_valid, 1);
        check("wb_rd", wb_rd, 5);
        check("wb_data", wb_data, 32'h1234);
        check("wb_no_redirect", redirect_valid, 0);

        send(OPK_BRANCH, BRF_EQ, 32'h0, SIGN_ZERO, 32'h100, 32'h20, 5'd0);
        check("eq_redirect_valid", redirect_valid, 1);
        check("eq_redirect_pc", redirect_pc, 32'h120);
        check("eq_no_wb", wb_valid, 0);
        send(OPK_WB, 3'b000, 32'hAA, SIGN_POS, 32'h0, 32'h0, 5'd7);
        check("eq_pulse_one_cycle", redirect_valid, 0);
        check("flush1_dropped", wb_valid, 0);
        send(OPK_WB, 3'b000, 32'hBB, SIGN_POS, 32'h0, 32'h0, 5'd8);
        check("flush2_dropped", wb_valid, 0);
        send(OPK_WB, 3'b000, 32'hCC, SIGN_POS, 32'h0, 32'h0, 5'd9);
        check("post_flush_valid", wb_valid, 1);
        check("post_flush_rd", wb_rd, 9);
        check("post_flush_data", wb_data, 32'hCC);

        send(OPK_BRANCH, BRF_LT, 32'h3, SIGN_POS, 32'h300, 32'h40, 5'd0);
        check("lt_not_taken", redirect_valid, 0);
        check("lt_no_wb", wb_valid, 0);
        send(OPK_WB, 3'b000, 32'hDD, SIGN_POS, 32'h0, 32'h0, 5'd10);
        check("after_lt_valid", wb_valid, 1);
        check("after_lt_rd", wb_rd, 10);

        send(OPK_JALR, 3'b000, 32'h305, SIGN_POS, 32'h200, 32'h0, 5'd1);
        check("jalr_wb_rd", wb_rd, 1);
        check("jalr_wb_data", wb_data, 32'h204);
        check("jalr_redirect_valid", redirect_valid, 1);
        check("jalr_redirect_pc", redirect_pc, 32'h304);
        send(OPK_WB, 3'b000, 32'h1, SIGN_POS, 32'h0, 32'h0, 5'd13);
        check("jalr_flush1", wb_valid, 0);
        send(OPK_WB, 3'b000, 32'h2, SIGN_POS, 32'h0, 32'h0, 5'd14);
        check("jalr_flush2", wb_valid, 0);

        send(OPK_WB, 3'b000, 32'h99, SIGN_POS, 32'h0, 32'h0, 5'd0);
        check("rd0_no_wb", wb_valid, 0);

        wb_ready = 1'b0;
        send(OPK_WB, 3'b000, 32'h33, SIGN_POS, 32'h0, 32'h0, 5'd3);
        check("bp_load", wb_valid, 1);
        @(negedge clk);
        set_op(OPK_WB, 3'b000, 32'h44, SIGN_POS, 32'h0, 32'h0, 5'd4);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready", in_ready, 0);
            check("bp_hold_rd", wb_rd, 3);
            check("bp_hold_data", wb_data, 32'h33);
            @(negedge clk);
        end
        wb_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_swap_valid", wb_valid, 1);
        check("bp_swap_rd", wb_rd, 4);
        check("bp_swap_data", wb_data, 32'h44);

        send(OPK_BRANCH, 3'b010, 32'h0, SIGN_ZERO, 32'h500, 32'h8, 5'd0);
        check("err_set", err_funct, 1);
        check("err_not_taken", redirect_valid, 0);
        send(OPK_WB, 3'b000, 32'h11, SIGN_POS, 32'h0, 32'h0, 5'd11);
        check("err_sticky", err_funct, 1);
        check("err_then_wb_rd", wb_rd, 11);
        check("stats_total", br_total, exp_total);
        check("stats_taken", br_taken, exp_taken);

        send(OPK_JAL, 3'b000, 32'h80, SIGN_POS, 32'hFFFF_FFFC, 32'h0, 5'd2);
        check("jal_wb_rd", wb_rd, 2);
        check("jal_link_wrap", wb_data, 32'h0);
        check("jal_redirect_pc", redirect_pc, 32'h80);
        send(OPK_WB, 3'b000, 32'h12, SIGN_POS, 32'h0, 32'h0, 5'd12);
        check("jal_flush1", wb_valid, 0);

        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_wb_valid", wb_valid, 0);
        check("mid_rst_wb_rd", wb_rd, 0);
        check("mid_rst_redirect_pc", redirect_pc, 0);
        check("mid_rst_err", err_funct, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_br_total", br_total, 0);
        @(negedge clk);
        rst = 1'b0;
        send(OPK_WB, 3'b000, 32'h66, SIGN_POS, 32'h0, 32'h0, 5'd6);
        check("after_rst_run_valid", wb_valid, 1);
        check("after_rst_run_data", wb_data, 32'h66);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scalar_branch_commit.md
# scalar_branch_commit

Consumer stage behind the scalar ALU. Takes each executed scalar op, its ALU result and sign code, and does three things: resolves conditional branches and jumps into a registered one-cycle PC redirect, writes back register results through a valid/ready output register, and squashes a fixed number of wrong-path ops after every redirect. It sits between scalar execute and the register-file write port and fetch unit.

## Interface
- LEN, 32: data/address width
- FLUSH_DEPTH, 2: wrong-path ops dropped after a redirect (1..7)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  op presented
- in_ready  out  1  op accepted when in_valid && in_ready
- op_kind  in  2  0 WB (plain writeback), 1 BRANCH, 2 JAL, 3 JALR
- br_funct  in  3  branch condition: 000 EQ, 001 NE, 100 LT, 101 GE
- alu_result  in  LEN  ALU result; rs1-rs2 for BRANCH, target for JAL/JALR
- sign_bits  in  2  ALU sign code (`POS`/`ZERO`/`NEG`)
- pc  in  LEN  op PC
- imm  in  LEN  branch offset
- rd  in  5  destination register
- wb_valid  out  1  writeback entry valid
- wb_ready  in  1  register file accepts entry
- wb_rd  out  5  writeback register
- wb_data  out  LEN  writeback data
- redirect_valid  out  1  one-cycle redirect pulse
- redirect_pc  out  LEN  new fetch PC
- err_funct  out  1  sticky: unsupported br_funct seen
- br_total, br_taken  out  32 each  statistics counters (see Configuration)

## Operation
- States: RUN, FLUSH.
- **RUN**
  - in_ready = !wb_valid || wb_ready.
  - WB op accepted: load wb entry with {rd, alu_result}.
  - BRANCH taken condition:
    - EQ: sign_bits==`ZERO`.
    - NE: sign_bits!=`ZERO`.
    - LT: alu_result[LEN-1]==1.
    - GE: alu_result[LEN-1]==0.
    - Other funct: not taken, set err_funct.
    - Branch produces no writeback.
  - Taken BRANCH: redirect_pc = pc+imm (LEN-bit wrap).
  - JAL: writeback {rd, pc+4}; redirect_pc = alu_result.
  - JALR: writeback {rd, pc+4}; redirect_pc = alu_result & ~1.
  - rd==0: no wb entry is loaded for any kind.
  - Any redirect moves the state to FLUSH and loads flush_cnt=FLUSH_DEPTH.
- **FLUSH**
  - in_ready=1 regardless of the writeback port.
  - Each accepted op is dropped: no writeback, no redirect, no err, no stats. flush_cnt decrements.
  - flush_cnt reaching 0 on an accept returns the state to RUN.
  - An existing wb entry still drains normally.
- **Writeback register**
  - A held entry keeps wb_rd/wb_data stable until wb_ready.
  - Simultaneous drain and load in the same cycle is allowed (full throughput).
- Arithmetic: pc+imm and pc+4 are modulo 2^LEN; no overflow flag.

## Timing
- Reset values: in_ready=1 during reset deassertion, wb_valid=0, wb_rd=0, wb_data=0, redirect_valid=0, redirect_pc=0, err_funct=0, counters=0. State RUN, flush_cnt=0.
- Latency: accept at edge N; wb_valid and redirect_valid are high after edge N (one cycle).
- redirect_valid lasts exactly one cycle and has no back-pressure.
- Back-to-back redirects cannot occur: the op accepted after a redirect is always in FLUSH.
- The first flushed op may be accepted in the cycle redirect_valid is high.
- rst mid-operation: all state is cleared immediately; a pending wb entry or redirect is lost.

## Configuration
- BRANCH_STATS_EN defined:
  - br_total increments on every accepted, non-flushed BRANCH.
  - br_taken increments on each taken BRANCH.
  - Both are 32-bit and wrap at 2^32.
- Not defined: br_total and br_taken are tied to 0 and no counter flops exist. Ports remain present.

## Structure
- Shared defines package holds:
  - `POS`/`ZERO`/`NEG` sign codes.
  - op_kind encodings (OPK_WB, OPK_BRANCH, OPK_JAL, OPK_JALR).
  - br_funct codes.
  - State encodings RUN/FLUSH.
- Sub-module branch_cond_eval: purely combinational taken/err decision from br_funct, sign_bits and alu_result MSB.
- Top level holds the FSM, wb register, redirect register and counters.

## Test plan
- WB op rd=5, alu_result=0x1234, wb_ready=1 -> next cycle wb_valid=1, wb_rd=5, wb_data=0x1234; no redirect.
- BRANCH EQ, sign_bits=`ZERO`, pc=0x100, imm=0x20 -> redirect_valid one cycle, redirect_pc=0x120. The next 2 ops are dropped and the third is written back.
- BRANCH LT, alu_result=0x0000_0003 -> not taken; no redirect; the next op is processed normally.
- JALR rd=1, pc=0x200, alu_result=0x305 -> wb {1, 0x204}, redirect_pc=0x304.
- wb_ready=0 for 3 cycles with an entry held -> in_ready=0 and the output stays stable. Then wb_ready=1 with a new op present -> drain and load in the same cycle.
- br_funct=010 -> err_funct=1 sticky, not taken; assert rst mid-flush -> all outputs 0 and state RUN. With BRANCH_STATS_EN: 3 branches, 1 taken -> br_total=3, br_taken=1.
